// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: a fetch port (read only) and a data port
// (read/write) share one memory port, with round-robin resolution of ties.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ready,
  input  logic            d_req,
  input  logic            d_wenable,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_wenable,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [1:0]      owner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_BUSY_IF = 2'b01,
    S_BUSY_D  = 2'b10
  } state_t;

  localparam logic [2:0] LP_LATENCY = 3'(READ_LATENCY);

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_count;
  logic              r_write;
  logic              r_last_d;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              w_grant_if;
  logic              w_grant_d;
  logic              w_unused;

  // Read data travels straight from memory to the requesters outside this block.
  assign w_unused = ^mem_rdata;

  assign owner     = r_state;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  always_comb begin
    w_state_next = r_state;
    w_grant_if   = 1'b0;
    w_grant_d    = 1'b0;
    if_ready     = 1'b0;
    d_ready      = 1'b0;
    mem_wenable  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (if_req && d_req) begin
          if (r_last_d) w_grant_if = 1'b1;
          else          w_grant_d  = 1'b1;
        end else if (if_req) begin
          w_grant_if = 1'b1;
        end else if (d_req) begin
          w_grant_d = 1'b1;
        end
        if (w_grant_if) w_state_next = S_BUSY_IF;
        if (w_grant_d)  w_state_next = S_BUSY_D;
      end
      S_BUSY_IF: begin
        if (r_count == 3'd0) begin
          if_ready     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_BUSY_D: begin
        // A write completes in its first busy cycle, regardless of the counter.
        if (r_write) begin
          mem_wenable  = 1'b1;
          d_ready      = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_count == 3'd0) begin
          d_ready      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= 3'd0;
      r_write  <= 1'b0;
      r_last_d <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_if) begin
        r_addr   <= if_addr;
        r_write  <= 1'b0;
        r_count  <= LP_LATENCY;
        r_last_d <= 1'b0;
      end else if (w_grant_d) begin
        r_addr   <= d_addr;
        r_wdata  <= d_wdata;
        r_write  <= d_wenable;
        r_count  <= LP_LATENCY;
        r_last_d <= 1'b1;
      end else if (r_state != S_IDLE && r_count != 3'd0) begin
        r_count <= r_count - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected transactions,
// per-instance monitors pop and compare whenever a ready pulse appears.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, reset_b;
  logic        if_req, if_req_b, d_req, d_req_b, d_wenable, d_wenable_b;
  logic [31:0] if_addr, if_addr_b, d_addr, d_addr_b, d_wdata, d_wdata_b;
  logic        if_ready, if_ready_b, d_ready, d_ready_b, mem_wenable, mem_wenable_b;
  logic [31:0] mem_addr, mem_addr_b, mem_wdata, mem_wdata_b;
  logic [31:0] mem_rdata = 32'h1234_5678;
  logic [1:0]  owner, owner_b;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          grant_cyc[2];
  int          last_ready[2];
  logic [1:0]  prev_owner[2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  mem_port_arbiter #(.XLEN(32), .READ_LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .d_req(d_req), .d_wenable(d_wenable), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wenable(mem_wenable), .mem_rdata(mem_rdata), .owner(owner)
  );

  mem_port_arbiter #(.XLEN(32), .READ_LATENCY(1)) dut_b (
    .clock(clock), .reset(reset_b),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_ready(if_ready_b),
    .d_req(d_req_b), .d_wenable(d_wenable_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_ready(d_ready_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_wenable(mem_wenable_b), .mem_rdata(mem_rdata), .owner(owner_b)
  );

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got 0x%0h, expected 0x%0h", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic score(input int inst, input logic got_if, input logic got_d,
                       input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   qsize;
    qsize = (inst == 0) ? q0.size() : q1.size();
    if (qsize == 0) begin
      chk("unexpected_ready", inst, 32'd1, 32'd0);
      return;
    end
    if (inst == 0) e = q0.pop_front();
    else           e = q1.pop_front();
    $display("inst%0d cyc%0d: %s %s addr=0x%h wdata=0x%h latency=%0d",
             inst, cyc, got_d ? "data" : "fetch", we ? "write" : "read",
             addr, wdata, cyc - grant_cyc[inst]);
    chk("ready_port_data", inst, 32'(got_d), 32'(e.is_d));
    chk("ready_port_fetch", inst, 32'(got_if), 32'(!e.is_d));
    chk("mem_addr", inst, addr, e.addr);
    chk("mem_wenable", inst, 32'(we), 32'(e.we));
    if (e.we) chk("mem_wdata", inst, wdata, e.wdata);
    chk("latency", inst, 32'(cyc - grant_cyc[inst]), 32'(e.lat));
  endtask

  task automatic monitor(input int inst, input logic ifr, input logic dr, input logic we,
                         input logic [1:0] own, input logic [31:0] addr,
                         input logic [31:0] wdata);
    if (own != 2'd0 && prev_owner[inst] == 2'd0) begin
      grant_cyc[inst] = cyc;
      chk("grant_spacing", inst, 32'(cyc - last_ready[inst] >= 2), 32'd1);
    end
    prev_owner[inst] = own;
    if (ifr || dr || we)
      chk("ready_exclusive_owned", inst,
          32'({ifr && dr, we && !(dr && own == 2'd2), ifr && own != 2'd1,
               dr && own != 2'd2}), 32'd0);
    if (ifr || dr) begin
      score(inst, ifr, dr, we, addr, wdata);
      last_ready[inst] = cyc;
    end
  endtask

  always @(negedge clock) monitor(0, if_ready, d_ready, mem_wenable, owner, mem_addr, mem_wdata);
  always @(negedge clock) monitor(1, if_ready_b, d_ready_b, mem_wenable_b, owner_b, mem_addr_b, mem_wdata_b);

  task automatic wait_owner(input int inst, input logic [1:0] val, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (((inst == 0) ? owner : owner_b) == val) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, inst, 32'(ok), 32'd1);
  endtask

  task automatic wait_ready(input int inst, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if ((inst == 0) ? (if_ready || d_ready) : (if_ready_b || d_ready_b)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, inst, 32'(ok), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_owner"}, 0, 32'(owner), 32'd0);
    chk({tag, "_mem_addr"}, 0, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, 0, mem_wdata, 32'd0);
    chk({tag, "_mem_wenable"}, 0, 32'(mem_wenable), 32'd0);
    chk({tag, "_if_ready"}, 0, 32'(if_ready), 32'd0);
    chk({tag, "_d_ready"}, 0, 32'(d_ready), 32'd0);
  endtask

  // Single transaction; after the grant the request is dropped and the inputs
  // scrambled, which must not disturb the latched transaction.
  task automatic txn(input int inst, input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int lat);
    exp_t e;
    e = '{is_d: is_d, we: we, addr: addr, wdata: wdata, lat: lat};
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
    if (inst == 0) begin
      if (is_d) begin d_wenable = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1; end
      else begin if_addr = addr; if_req = 1'b1; end
    end else begin
      if (is_d) begin d_wenable_b = we; d_addr_b = addr; d_wdata_b = wdata; d_req_b = 1'b1; end
      else begin if_addr_b = addr; if_req_b = 1'b1; end
    end
    wait_owner(inst, is_d ? 2'd2 : 2'd1, "grant");
    chk("mem_addr_at_grant", inst, (inst == 0) ? mem_addr : mem_addr_b, addr);
    if (inst == 0) begin
      if_req = 1'b0; d_req = 1'b0; d_wenable = 1'b0;
      if_addr = ~addr; d_addr = ~addr; d_wdata = ~wdata;
    end else begin
      if_req_b = 1'b0; d_req_b = 1'b0; d_wenable_b = 1'b0;
      if_addr_b = ~addr; d_addr_b = ~addr; d_wdata_b = ~wdata;
    end
    if (lat > 0) wait_ready(inst, "ready");
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw;
    for (int i = 0; i < 2; i++) begin
      grant_cyc[i] = 0; last_ready[i] = -1000; prev_owner[i] = 2'd0;
    end
    reset = 1'b1; reset_b = 1'b1;
    if_req = 0; d_req = 0; d_wenable = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    if_req_b = 0; d_req_b = 0; d_wenable_b = 0; if_addr_b = 0; d_addr_b = 0; d_wdata_b = 0;
    repeat (2) @(negedge clock);
    check_reset_state("por");
    reset = 1'b0; reset_b = 1'b0;
    @(negedge clock);

    // Tie held for four transactions after reset: fetch, data, fetch, data.
    q0.push_back('{is_d: 1'b0, we: 1'b0, addr: 32'h1000, wdata: 32'h0, lat: 2});
    q0.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h2000, wdata: 32'h0, lat: 2});
    q0.push_back('{is_d: 1'b0, we: 1'b0, addr: 32'h1000, wdata: 32'h0, lat: 2});
    q0.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h2000, wdata: 32'h0, lat: 2});
    if_addr = 32'h1000; d_addr = 32'h2000; d_wenable = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int r = 0; r < 4; r++) wait_ready(0, "tie_ready");
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clock);

    txn(0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 2);
    txn(0, 1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_BABE, 0);
    txn(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 2);

    // Fetch aborted by reset while its counter is at 1: no ready may follow.
    if_addr = 32'h3000; if_req = 1'b1;
    wait_owner(0, 2'd1, "abort_grant");
    @(negedge clock);
    reset = 1'b1; if_req = 1'b0;
    @(negedge clock);
    check_reset_state("abort");
    reset = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (if_ready || d_ready) saw = 1'b1;
    end
    chk("no_ready_after_abort", 0, 32'(saw), 32'd0);

    // Tie right after reset: fetch first, data (a write) one idle cycle later.
    q0.push_back('{is_d: 1'b0, we: 1'b0, addr: 32'h5000, wdata: 32'h0, lat: 2});
    q0.push_back('{is_d: 1'b1, we: 1'b1, addr: 32'h6000, wdata: 32'h1111_2222, lat: 0});
    if_addr = 32'h5000; d_addr = 32'h6000; d_wdata = 32'h1111_2222; d_wenable = 1'b1;
    if_req = 1'b1; d_req = 1'b1;
    wait_ready(0, "tie2_fetch_ready");
    if_req = 1'b0;
    wait_ready(0, "tie2_data_ready");
    d_req = 1'b0; d_wenable = 1'b0;
    repeat (3) @(negedge clock);

    txn(0, 1'b0, 1'b0, 32'h0000_4000, 32'h0, 2);

    // Single-cycle read latency instance.
    txn(1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 1);
    txn(1, 1'b1, 1'b1, 32'h0000_0066, 32'h0000_0077, 0);
    txn(1, 1'b1, 1'b0, 32'h0000_0088, 32'h0, 1);

    repeat (4) @(negedge clock);
    chk("queue0_drained", 0, 32'(q0.size()), 32'd0);
    chk("queue1_drained", 1, 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
